// File: rtl/bg_pixel_engine_if.sv
// Bundles the handshake, configuration and result signals of bg_pixel_engine.
// The slave modport is the engine's view; master is the controller's view.
interface bg_pixel_engine_if #(
    parameter int NUM_PIXELS = 4,
    parameter int PIX_W      = 8
);
    localparam int SUM_W  = PIX_W + $clog2(NUM_PIXELS + 1);
    localparam int DIST_W = 2 * PIX_W + 2;
    localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam int VEC_W  = NUM_PIXELS * PIX_W;

    // Handshake: Start is taken only in IDLE, Ack only in DONE; Done stays
    // high until the edge at which Ack is seen, results hold until next Start.
    logic              Start;
    logic              Ack;
    logic [1:0]        Mode;
    logic [PIX_W-1:0]  Red_Exp;
    logic [PIX_W-1:0]  Green_Exp;
    logic [PIX_W-1:0]  Blue_Exp;
    logic [DIST_W-1:0] Threshold;
    logic [PIX_W-1:0]  Desired_Bg_R;
    logic [PIX_W-1:0]  Desired_Bg_G;
    logic [PIX_W-1:0]  Desired_Bg_B;
    logic [VEC_W-1:0]  Red_In;
    logic [VEC_W-1:0]  Green_In;
    logic [VEC_W-1:0]  Blue_In;
    logic [VEC_W-1:0]  Red_Out;
    logic [VEC_W-1:0]  Green_Out;
    logic [VEC_W-1:0]  Blue_Out;
    logic [SUM_W-1:0]  Red_Sum;
    logic [SUM_W-1:0]  Green_Sum;
    logic [SUM_W-1:0]  Blue_Sum;
    logic [CNT_W-1:0]  Bg_Count;
    logic              Busy;
    logic              Done;
    logic              Qi;
    logic              Qr;
    logic              Qd;

    modport master (
        output Start, Ack, Mode, Red_Exp, Green_Exp, Blue_Exp, Threshold,
               Desired_Bg_R, Desired_Bg_G, Desired_Bg_B, Red_In, Green_In, Blue_In,
        input  Red_Out, Green_Out, Blue_Out, Red_Sum, Green_Sum, Blue_Sum,
               Bg_Count, Busy, Done, Qi, Qr, Qd
    );

    modport slave (
        input  Start, Ack, Mode, Red_Exp, Green_Exp, Blue_Exp, Threshold,
               Desired_Bg_R, Desired_Bg_G, Desired_Bg_B, Red_In, Green_In, Blue_In,
        output Red_Out, Green_Out, Blue_Out, Red_Sum, Green_Sum, Blue_Sum,
               Bg_Count, Busy, Done, Qi, Qr, Qd
    );
endinterface

// File: rtl/bg_pixel_engine.sv
// Background-removal PE: latches a block of NUM_PIXELS RGB pixels, processes one
// per clock (channel sums and/or threshold replacement) under Start/Done/Ack.
module bg_pixel_engine #(
    parameter int NUM_PIXELS = 4,
    parameter int PIX_W      = 8
) (
    input logic              Clk,
    input logic              Reset_n,
    bg_pixel_engine_if.slave bus
);
    localparam int SUM_W  = PIX_W + $clog2(NUM_PIXELS + 1);
    localparam int DIST_W = 2 * PIX_W + 2;
    localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam int VEC_W  = NUM_PIXELS * PIX_W;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_mode;
    logic [PIX_W-1:0]  r_exp_r, r_exp_g, r_exp_b;
    logic [PIX_W-1:0]  r_des_r, r_des_g, r_des_b;
    logic [DIST_W-1:0] r_thr;
    logic [VEC_W-1:0]  r_red_in, r_green_in, r_blue_in;
    logic [VEC_W-1:0]  r_red_out, r_green_out, r_blue_out;
    logic [SUM_W-1:0]  r_red_sum, r_green_sum, r_blue_sum;
    logic [CNT_W-1:0]  r_bg_cnt;

    logic [PIX_W-1:0]          w_pix_r, w_pix_g, w_pix_b;
    logic signed [PIX_W:0]     w_dr, w_dg, w_db;
    logic signed [DIST_W-1:0]  w_sq_r, w_sq_g, w_sq_b;
    logic [DIST_W-1:0]         w_dist;
    logic                      w_hit;
    logic                      w_last;

    assign w_pix_r = r_red_in[r_cnt*PIX_W +: PIX_W];
    assign w_pix_g = r_green_in[r_cnt*PIX_W +: PIX_W];
    assign w_pix_b = r_blue_in[r_cnt*PIX_W +: PIX_W];

    // Zero-extend before subtracting so the difference is a proper signed value.
    assign w_dr = $signed({1'b0, w_pix_r}) - $signed({1'b0, r_exp_r});
    assign w_dg = $signed({1'b0, w_pix_g}) - $signed({1'b0, r_exp_g});
    assign w_db = $signed({1'b0, w_pix_b}) - $signed({1'b0, r_exp_b});

    assign w_sq_r = w_dr * w_dr;
    assign w_sq_g = w_dg * w_dg;
    assign w_sq_b = w_db * w_db;
    assign w_dist = $unsigned(w_sq_r) + $unsigned(w_sq_g) + $unsigned(w_sq_b);

    assign w_hit  = r_mode[1] && (w_dist <= r_thr);
    assign w_last = (r_cnt == CNT_W'(NUM_PIXELS - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_exp_r     <= '0;
            r_exp_g     <= '0;
            r_exp_b     <= '0;
            r_des_r     <= '0;
            r_des_g     <= '0;
            r_des_b     <= '0;
            r_thr       <= '0;
            r_red_in    <= '0;
            r_green_in  <= '0;
            r_blue_in   <= '0;
            r_red_out   <= '0;
            r_green_out <= '0;
            r_blue_out  <= '0;
            r_red_sum   <= '0;
            r_green_sum <= '0;
            r_blue_sum  <= '0;
            r_bg_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_mode      <= bus.Mode;
                        r_exp_r     <= bus.Red_Exp;
                        r_exp_g     <= bus.Green_Exp;
                        r_exp_b     <= bus.Blue_Exp;
                        r_des_r     <= bus.Desired_Bg_R;
                        r_des_g     <= bus.Desired_Bg_G;
                        r_des_b     <= bus.Desired_Bg_B;
                        r_thr       <= bus.Threshold;
                        r_red_in    <= bus.Red_In;
                        r_green_in  <= bus.Green_In;
                        r_blue_in   <= bus.Blue_In;
                        r_red_sum   <= '0;
                        r_green_sum <= '0;
                        r_blue_sum  <= '0;
                        r_bg_cnt    <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_red_out[r_cnt*PIX_W +: PIX_W]   <= w_hit ? r_des_r : w_pix_r;
                    r_green_out[r_cnt*PIX_W +: PIX_W] <= w_hit ? r_des_g : w_pix_g;
                    r_blue_out[r_cnt*PIX_W +: PIX_W]  <= w_hit ? r_des_b : w_pix_b;
                    // Sums always take the original pixel, never the replacement.
                    if (r_mode[0]) begin
                        r_red_sum   <= r_red_sum + SUM_W'(w_pix_r);
                        r_green_sum <= r_green_sum + SUM_W'(w_pix_g);
                        r_blue_sum  <= r_blue_sum + SUM_W'(w_pix_b);
                    end
                    if (w_hit) begin
                        r_bg_cnt <= r_bg_cnt + CNT_W'(1);
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.Ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Red_Out   = r_red_out;
    assign bus.Green_Out = r_green_out;
    assign bus.Blue_Out  = r_blue_out;
    assign bus.Red_Sum   = r_red_sum;
    assign bus.Green_Sum = r_green_sum;
    assign bus.Blue_Sum  = r_blue_sum;
    assign bus.Bg_Count  = r_bg_cnt;
    assign bus.Qi        = r_state[0];
    assign bus.Qr        = r_state[1];
    assign bus.Qd        = r_state[2];
    assign bus.Busy      = r_state[1];
    assign bus.Done      = r_state[2];
endmodule
